uart_tx_framer: RTL and testbench

UART_TX_FRAMER -- requirements
Module: uart_tx_framer

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_bit_timer.sv | 47 ++++
 rtl/uart_tx_framer.sv | 198 +++++++++++++++++++
 tb/tb_uart_tx_framer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and defaults for the UART blocks (transmitter now, receiver
// later).
//   parity_e   : parity mode selector (NONE / ODD / EVEN)
//   tx_state_e : transmit framer FSM states
//   UART_DEFAULT_OVERSAMPLE, UART_DEFAULT_DATA_BITS : default parameter values
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [1:0] {
      PARITY_NONE,
      PARITY_ODD,
      PARITY_EVEN
   } parity_e;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } tx_state_e;

   localparam int UART_DEFAULT_OVERSAMPLE = 16;
   localparam int UART_DEFAULT_DATA_BITS  = 8;

endpackage : uart_pkg

// File: rtl/uart_bit_timer.sv
// -----------------------------------------------------------------------------
// uart_bit_timer
// Oversample down-counter marking bit boundaries. The counter runs from
// OVERSAMPLE-1 down to 0 and reloads by itself, so one bit period lasts exactly
// OVERSAMPLE clk cycles. 'load' restarts the period so that a new frame lines
// up with the transfer edge. Intended to be shared with a future receiver.
// Ports:
//   clk      : oversample clock
//   rst      : asynchronous active-high reset (counter cleared to 0)
//   load     : restart a bit period on the next edge
//   bit_done : high during the final clk cycle of the current bit period
// -----------------------------------------------------------------------------
module uart_bit_timer
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = UART_DEFAULT_OVERSAMPLE
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   output logic bit_done
);

   localparam int            CW     = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0] RELOAD = CW'(OVERSAMPLE - 1);

   if (OVERSAMPLE < 2) begin : g_bad_oversample
      $error("uart_bit_timer: OVERSAMPLE must be at least 2");
   end

   logic [CW-1:0] cnt;

   // NOTE: registers are written only with non-blocking assignments so every
   // flop samples the pre-edge value of every other flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load || (cnt == '0)) begin
         cnt <= RELOAD;
      end else begin
         cnt <= cnt - 1'b1;
      end
   end

   assign bit_done = (cnt == '0);

endmodule : uart_bit_timer

// File: rtl/uart_tx_framer.sv
// -----------------------------------------------------------------------------
// uart_tx_framer
// Serialises one word per valid/ready handshake into an asynchronous frame:
// start bit (0), DATA_BITS data bits LSB first, optional parity bit, then
// STOP_BITS stop bits (1). Every bit lasts OVERSAMPLE clk cycles.
// ready is also raised in the last cycle of the final stop bit so that a
// waiting word follows with no idle gap.
//
// Build option: define UART_TX_FRAMER_PARITY_EN to compile in the parity state
// and parity generation. Without it the PARITY parameter is ignored (treated as
// NONE, with an elaboration warning if it asks for parity).
//
// Ports:
//   clk         : clock, OVERSAMPLE x bitrate
//   rst         : asynchronous active-high reset; aborts any frame in flight
//   data        : word to transmit, captured on the transfer edge
//   valid       : a word is offered
//   ready       : a word is accepted this cycle if valid is high
//   serial_data : line output, idle mark = 1
//   busy        : a frame is in progress
// -----------------------------------------------------------------------------
module uart_tx_framer
   import uart_pkg::*;
#(
   parameter int      DATA_BITS  = UART_DEFAULT_DATA_BITS,
   parameter int      OVERSAMPLE = UART_DEFAULT_OVERSAMPLE,
   parameter int      STOP_BITS  = 1,
   parameter parity_e PARITY     = PARITY_NONE
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] data,
   input  logic                 valid,
   output logic                 ready,
   output logic                 serial_data,
   output logic                 busy
);

   // ---------------------------------------------------------------------------
   // Parameter checks
   // ---------------------------------------------------------------------------
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_framer: DATA_BITS must be in 5..9");
   end
   if (OVERSAMPLE < 2 || OVERSAMPLE > 256) begin : g_bad_oversample
      $error("uart_tx_framer: OVERSAMPLE must be in 2..256");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $error("uart_tx_framer: STOP_BITS must be 1 or 2");
   end

`ifdef UART_TX_FRAMER_PARITY_EN
   localparam bit PAR_ON = (PARITY != PARITY_NONE);
`else
   if (PARITY != PARITY_NONE) begin : g_parity_ignored
      $warning("uart_tx_framer: parity support not compiled in, PARITY treated as NONE");
   end
`endif

   // Bit counter indexes data bits and, reused, stop bits.
   localparam int            BW        = $clog2(DATA_BITS + 1);
   localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

   tx_state_e            state;
   tx_state_e            state_next;
   logic [DATA_BITS-1:0] shreg;
   logic [BW-1:0]        bit_cnt;
   logic                 armed;
   logic                 bit_done;
   logic                 last_stop;
   logic                 xfer;
`ifdef UART_TX_FRAMER_PARITY_EN
   logic                 parity_bit;
`endif

   // ---------------------------------------------------------------------------
   // Bit timing
   // ---------------------------------------------------------------------------
   uart_bit_timer #(
      .OVERSAMPLE (OVERSAMPLE)
   ) u_bit_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (xfer),
      .bit_done (bit_done)
   );

   // ---------------------------------------------------------------------------
   // Handshake
   // ---------------------------------------------------------------------------
   // 'armed' keeps ready low while rst is held and until the first edge after
   // release, even though the FSM already sits in IDLE.
   assign last_stop = (state == TX_STOP) && bit_done && (bit_cnt == LAST_STOP);
   assign ready     = armed && ((state == TX_IDLE) || last_stop);
   assign xfer      = valid && ready;
   assign busy      = (state != TX_IDLE);

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= TX_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------------------
   // NOTE: every signal driven from always_comb gets a default first, so no
   // path through the block can leave it unassigned and infer a latch.
   always_comb begin
      state_next = state;
      unique case (state)
         TX_IDLE: begin
            if (xfer) state_next = TX_START;
         end
         TX_START: begin
            if (bit_done) state_next = TX_DATA;
         end
         TX_DATA: begin
            if (bit_done && (bit_cnt == LAST_DATA)) begin
`ifdef UART_TX_FRAMER_PARITY_EN
               state_next = PAR_ON ? TX_PARITY : TX_STOP;
`else
               state_next = TX_STOP;
`endif
            end
         end
`ifdef UART_TX_FRAMER_PARITY_EN
         TX_PARITY: begin
            if (bit_done) state_next = TX_STOP;
         end
`endif
         TX_STOP: begin
            if (xfer)           state_next = TX_START;
            else if (last_stop) state_next = TX_IDLE;
         end
         default: state_next = TX_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Line output, decoded from registered state only
   // ---------------------------------------------------------------------------
   always_comb begin
      serial_data = 1'b1;
      case (state)
         TX_START:  serial_data = 1'b0;
         TX_DATA:   serial_data = shreg[0];
`ifdef UART_TX_FRAMER_PARITY_EN
         TX_PARITY: serial_data = parity_bit;
`endif
         default:   serial_data = 1'b1;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath: shift register, bit counter, parity
   // ---------------------------------------------------------------------------
   // NOTE: the reset is asynchronous so the line returns to mark the moment
   // rst rises; this block holds only a few flops, so all of them are cleared.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg      <= '0;
         bit_cnt    <= '0;
         armed      <= 1'b0;
`ifdef UART_TX_FRAMER_PARITY_EN
         parity_bit <= 1'b0;
`endif
      end else begin
         armed <= 1'b1;
         if (xfer) begin
            shreg      <= data;
            bit_cnt    <= '0;
`ifdef UART_TX_FRAMER_PARITY_EN
            // Even: XOR of the word; odd: its inverse.
            parity_bit <= (^data) ^ (PARITY == PARITY_ODD);
`endif
         end else if (bit_done) begin
            case (state)
               TX_DATA: begin
                  shreg   <= shreg >> 1;
                  bit_cnt <= (bit_cnt == LAST_DATA) ? '0 : bit_cnt + 1'b1;
               end
               TX_STOP: begin
                  bit_cnt <= (bit_cnt == LAST_STOP) ? '0 : bit_cnt + 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule : uart_tx_framer

// File: tb/tb_uart_tx_framer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_framer
// Self-checking bench for uart_tx_framer. Drives a default instance
// (8 data bits, x16, 1 stop) and a small instance (7 data bits, x4, 2 stop);
// with UART_TX_FRAMER_PARITY_EN defined it also drives EVEN and ODD parity
// instances. Inputs change and outputs are sampled on the falling clk edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_framer;
   import uart_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [7:0] drv_data;
   logic       drv_valid;
   int         sel;

   int errors = 0;
   int checks = 0;

   localparam int NO_LIMIT  = 1 << 30;
   localparam int NO_INJECT = -10;

`ifdef UART_TX_FRAMER_PARITY_EN
   localparam int N_SEL = 4;
`else
   localparam int N_SEL = 2;
`endif
   // Per-instance configuration, indexed by sel.
   int      os_of  [4] = '{16, 4, 16, 16};
   int      nd_of  [4] = '{8, 7, 8, 8};
   int      ns_of  [4] = '{1, 2, 1, 1};
   parity_e par_of [4] = '{PARITY_NONE, PARITY_NONE, PARITY_EVEN, PARITY_ODD};

   // ---------------------------------------------------------------------------
   // DUTs
   // ---------------------------------------------------------------------------
   logic valid_a, ready_a, line_a, busy_a;
   logic valid_b, ready_b, line_b, busy_b;
   assign valid_a = drv_valid && (sel == 0);
   assign valid_b = drv_valid && (sel == 1);

   uart_tx_framer dut_a (
      .clk (clk), .rst (rst), .data (drv_data), .valid (valid_a),
      .ready (ready_a), .serial_data (line_a), .busy (busy_a)
   );

   uart_tx_framer #(.DATA_BITS(7), .OVERSAMPLE(4), .STOP_BITS(2)) dut_b (
      .clk (clk), .rst (rst), .data (drv_data[6:0]), .valid (valid_b),
      .ready (ready_b), .serial_data (line_b), .busy (busy_b)
   );

`ifdef UART_TX_FRAMER_PARITY_EN
   logic valid_e, ready_e, line_e, busy_e;
   logic valid_o, ready_o, line_o, busy_o;
   assign valid_e = drv_valid && (sel == 2);
   assign valid_o = drv_valid && (sel == 3);

   uart_tx_framer #(.PARITY(PARITY_EVEN)) dut_e (
      .clk (clk), .rst (rst), .data (drv_data), .valid (valid_e),
      .ready (ready_e), .serial_data (line_e), .busy (busy_e)
   );

   uart_tx_framer #(.PARITY(PARITY_ODD)) dut_o (
      .clk (clk), .rst (rst), .data (drv_data), .valid (valid_o),
      .ready (ready_o), .serial_data (line_o), .busy (busy_o)
   );
`endif

   logic obs_line, obs_busy, obs_ready;
   always_comb begin
      obs_line  = line_a;
      obs_busy  = busy_a;
      obs_ready = ready_a;
      case (sel)
         1: begin obs_line = line_b; obs_busy = busy_b; obs_ready = ready_b; end
`ifdef UART_TX_FRAMER_PARITY_EN
         2: begin obs_line = line_e; obs_busy = busy_e; obs_ready = ready_e; end
         3: begin obs_line = line_o; obs_busy = busy_o; obs_ready = ready_o; end
`endif
         default: ;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Reference model: frame as a list of line bits, LSB of f sent first
   // ---------------------------------------------------------------------------
   function automatic int frame_bits(input logic [7:0] d, input int nd,
                                     input parity_e par, input int ns,
                                     output logic [15:0] f);
      int n    = 0;
      int ones = 0;
      f = '1;
      f[n] = 1'b0; n++;
      for (int i = 0; i < nd; i++) begin
         f[n] = d[i]; n++;
         ones += int'(d[i]);
      end
      if (par == PARITY_EVEN) begin f[n] = ((ones % 2) == 1); n++; end
      if (par == PARITY_ODD)  begin f[n] = ((ones % 2) == 0); n++; end
      for (int i = 0; i < ns; i++) begin f[n] = 1'b1; n++; end
      return n;
   endfunction

   // ---------------------------------------------------------------------------
   // Helpers
   // ---------------------------------------------------------------------------
   task automatic check(input string name, input logic [31:0] actual,
                        input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic select(input int s);
      sel = s;
      #1;
   endtask

   task automatic send(input string tag, input logic [7:0] d);
      check({tag, " ready before send"}, obs_ready, 1);
      drv_data  = d;
      drv_valid = 1'b1;
      tick();
      drv_valid = 1'b0;
   endtask

   // Checks cycles 1..total of a frame (cycle 1 = first cycle after the
   // transfer edge). Ends sitting in the last checked cycle.
   task automatic check_frame(input string tag, input logic [15:0] f,
                              input int nbits, input int os, input int stop_at,
                              input int inject_at, input logic [7:0] inject_data);
      int total = nbits * os;
      for (int k = 1; k <= total && k <= stop_at; k++) begin
         check($sformatf("%s line c%0d", tag, k), obs_line, f[(k-1)/os]);
         check($sformatf("%s busy c%0d", tag, k), obs_busy, 1);
         check($sformatf("%s ready c%0d", tag, k), obs_ready, (k == total));
         if (k == inject_at) begin
            drv_data  = inject_data;
            drv_valid = 1'b1;
         end else if (k == inject_at + 1) begin
            drv_valid = 1'b0;
         end
         if (k < total && k < stop_at) tick();
      end
   endtask

   task automatic check_idle(input string tag);
      tick();
      check({tag, " idle line"}, obs_line, 1);
      check({tag, " idle busy"}, obs_busy, 0);
      check({tag, " idle ready"}, obs_ready, 1);
   endtask

   // ---------------------------------------------------------------------------
   // Directed vectors
   // ---------------------------------------------------------------------------
   typedef struct {
      int          sel;
      logic [7:0]  data;
      logic [15:0] frame;
      int          nbits;
      string       name;
   } vec_t;

   vec_t vecs[$];

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [15:0] f;
      logic [7:0]  d;
      int          nb;
      int          s;

      vecs.push_back('{0, 8'hA5, 16'h034A, 10, "A5"});
      vecs.push_back('{0, 8'h3C, 16'h0278, 10, "3C"});
      vecs.push_back('{0, 8'hFF, 16'h03FE, 10, "FF"});
      vecs.push_back('{1, 8'h41, 16'h0382, 10, "b 41"});
      vecs.push_back('{1, 8'h2A, 16'h0354, 10, "b 2A"});
`ifdef UART_TX_FRAMER_PARITY_EN
      vecs.push_back('{2, 8'h07, 16'h060E, 11, "even 07"});
      vecs.push_back('{3, 8'h07, 16'h040E, 11, "odd 07"});
`endif

      sel       = 0;
      drv_valid = 1'b0;
      drv_data  = '0;
      rst       = 1'b0;

      // Reset takes effect before any clock edge.
      #1 rst = 1'b1;
      #2;
      for (int i = 0; i < N_SEL; i++) begin
         select(i);
         check($sformatf("reset line %0d", i),  obs_line, 1);
         check($sformatf("reset busy %0d", i),  obs_busy, 0);
         check($sformatf("reset ready %0d", i), obs_ready, 0);
      end
      select(0);
      @(negedge clk);
      @(negedge clk);
      check("ready held in reset", obs_ready, 0);
      rst = 1'b0;
      #1 check("ready before first edge", obs_ready, 0);
      @(negedge clk);
      check("ready after first edge", obs_ready, 1);
      check("busy after reset", obs_busy, 0);

      // Table of single frames.
      foreach (vecs[i]) begin
         select(vecs[i].sel);
         send(vecs[i].name, vecs[i].data);
         check_frame(vecs[i].name, vecs[i].frame, vecs[i].nbits,
                     os_of[vecs[i].sel], NO_LIMIT, NO_INJECT, 8'h00);
         check_idle(vecs[i].name);
      end

      // valid held high across two words: the second frame starts straight
      // after the first stop bit.
      select(0);
      check("b2b ready", obs_ready, 1);
      drv_data  = 8'h55;
      drv_valid = 1'b1;
      tick();
      drv_data = 8'hAA;
      check_frame("b2b 55", 16'h02AA, 10, 16, NO_LIMIT, NO_INJECT, 8'h00);
      tick();
      drv_valid = 1'b0;
      check_frame("b2b AA", 16'h0354, 10, 16, NO_LIMIT, NO_INJECT, 8'h00);
      check_idle("b2b");

      // valid pulsed mid-frame is ignored and new data does not leak in.
      send("ignore", 8'h00);
      check_frame("ignore", 16'h0200, 10, 16, NO_LIMIT, 50, 8'hFF);
      check_idle("ignore");

      // Reset mid-frame aborts; the line returns to mark without a clock edge.
      send("abort", 8'h81);
      check_frame("abort", 16'h0302, 10, 16, 70, NO_INJECT, 8'h00);
      check("abort line before rst", obs_line, 0);
      #1 rst = 1'b1;
      #1;
      check("abort line async", obs_line, 1);
      check("abort busy async", obs_busy, 0);
      check("abort ready async", obs_ready, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1 check("abort ready before edge", obs_ready, 0);
      @(negedge clk);
      check("abort ready after edge", obs_ready, 1);
      check("abort busy after edge", obs_busy, 0);
      check("abort line after edge", obs_line, 1);
      send("post-abort 3C", 8'h3C);
      check_frame("post-abort 3C", 16'h0278, 10, 16, NO_LIMIT, NO_INJECT, 8'h00);
      check_idle("post-abort 3C");

      // Random words on random instances against the reference model.
      for (int n = 0; n < 16; n++) begin
         s = int'($urandom_range(0, N_SEL - 1));
         select(s);
         repeat ($urandom_range(0, 3)) tick();
         d  = 8'($urandom);
         nb = frame_bits(d, nd_of[s], par_of[s], ns_of[s], f);
         send($sformatf("rand%0d", n), d);
         check_frame($sformatf("rand%0d s%0d d%0h", n, s, d), f, nb, os_of[s],
                     NO_LIMIT, NO_INJECT, 8'h00);
         check_idle($sformatf("rand%0d", n));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_uart_tx_framer
